sprite_cmd_encoder: RTL and testbench

- Producer side of the 32-bit sprite command bus consumed by the per-type sprite display blocks.
- Accepts whole-sprite descriptors and frame-end requests over valid/ready handshakes.
- Serialises each descriptor into four field-write words targeting the back (non-displayed) ping-pong buffer.
- Issues the buffer-swap (flush) word during vertical blanking and tracks which buffer is front.

---
 rtl/sprite_cmd_pkg.sv | 74 +++++++
 rtl/sprite_cmd_encoder.sv | 129 ++++++++++++
 tb/tb_sprite_cmd_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the 32-bit sprite command bus: field layout, info/type codes,
// FSM state codes, the descriptor payload and the word pack helper.
package sprite_cmd_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SUB_W   = 6;
  localparam int unsigned CHILD_W = 5;
  localparam int unsigned INFO_W  = 4;
  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned MSG_W   = 13;
  localparam int unsigned PAT_W   = 5;
  localparam int unsigned COORD_W = 10;

  localparam int unsigned SUB_LSB   = 26;
  localparam int unsigned CHILD_LSB = 21;
  localparam int unsigned INFO_LSB  = 17;
  localparam int unsigned TYPE_LSB  = 14;
  localparam int unsigned PP_BIT    = 13;

  localparam logic [INFO_W-1:0] WRITE_INFO_DEF = 4'h1;
  localparam logic [INFO_W-1:0] FLUSH_INFO_DEF = 4'hF;

  localparam logic [TYPE_W-1:0] TYPE_NONE  = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_ATTR  = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_X     = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_Y     = 3'b011;
  localparam logic [TYPE_W-1:0] TYPE_SHIFT = 3'b100;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_W_ATTR   = 3'd1;
  localparam logic [2:0] ST_W_X      = 3'd2;
  localparam logic [2:0] ST_W_Y      = 3'd3;
  localparam logic [2:0] ST_W_SHIFT  = 3'd4;
  localparam logic [2:0] ST_WAIT_VBL = 3'd5;
  localparam logic [2:0] ST_FLUSH    = 3'd6;

  typedef struct packed {
    logic [SUB_W-1:0]   sub_comp;
    logic [CHILD_W-1:0] child;
    logic               visible;
    logic               flip;
    logic [PAT_W-1:0]   pattern;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] shift;
    logic               pp_selc;
  } spr_desc_t;

  function automatic logic [DATA_W-1:0] pack_word(
    input logic [SUB_W-1:0]   sub_comp,
    input logic [CHILD_W-1:0] child,
    input logic [INFO_W-1:0]  info,
    input logic [TYPE_W-1:0]  typ,
    input logic               pp_selc,
    input logic [MSG_W-1:0]   msg
  );
    return (DATA_W'(sub_comp) << SUB_LSB) | (DATA_W'(child) << CHILD_LSB) |
           (DATA_W'(info) << INFO_LSB) | (DATA_W'(typ) << TYPE_LSB) |
           (DATA_W'(pp_selc) << PP_BIT) | DATA_W'(msg);
  endfunction

  function automatic logic [MSG_W-1:0] attr_msg(
    input logic             visible,
    input logic             flip,
    input logic [PAT_W-1:0] pattern
  );
    return {visible, flip, 6'd0, pattern};
  endfunction

  function automatic logic [MSG_W-1:0] coord_msg(input logic [COORD_W-1:0] v);
    return {3'd0, v};
  endfunction

endpackage

// File: rtl/sprite_cmd_encoder.sv
// Serialises sprite descriptors into four back-buffer field writes and issues the
// vblank-aligned buffer flush, tracking which ping-pong buffer is on screen.
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter logic [INFO_W-1:0] WRITE_INFO  = WRITE_INFO_DEF,
  parameter logic [INFO_W-1:0] FLUSH_INFO  = FLUSH_INFO_DEF,
  parameter logic [DATA_W-1:0] IDLE_WORD   = 32'h0,
  parameter bit                VBLANK_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spr_valid,
  output logic               spr_ready,
  input  logic [SUB_W-1:0]   spr_sub_comp,
  input  logic [CHILD_W-1:0] spr_child,
  input  logic               spr_visible,
  input  logic               spr_flip,
  input  logic [PAT_W-1:0]   spr_pattern,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic [COORD_W-1:0] spr_shift,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               vblank,
  output logic [DATA_W-1:0]  writedata,
  output logic               word_strobe,
  output logic               front_buf
);

  logic [2:0]        state_q, state_d;
  spr_desc_t         desc_q, desc_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              word_strobe_q, word_strobe_d;
  logic              front_buf_q, front_buf_d;
  logic              idle_q, idle_d;
  logic              spr_acc, frame_acc;

  // idle_q is low during reset so neither handshake completes until the first edge
  assign spr_ready   = idle_q;
  assign frame_ready = idle_q & ~spr_valid;
  assign spr_acc     = spr_valid & idle_q;
  assign frame_acc   = frame_valid & idle_q & ~spr_valid;

  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    front_buf_d   = front_buf_q;
    writedata_d   = IDLE_WORD;
    word_strobe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (spr_acc) begin
          desc_d = '{sub_comp: spr_sub_comp, child: spr_child, visible: spr_visible,
                     flip: spr_flip, pattern: spr_pattern, x: spr_x, y: spr_y,
                     shift: spr_shift, pp_selc: ~front_buf_q};
          state_d = ST_W_ATTR;
        end else if (frame_acc) begin
          state_d = ST_WAIT_VBL;
        end
      end
      ST_W_ATTR:   state_d = ST_W_X;
      ST_W_X:      state_d = ST_W_Y;
      ST_W_Y:      state_d = ST_W_SHIFT;
      ST_W_SHIFT:  state_d = ST_IDLE;
      ST_WAIT_VBL: if (!VBLANK_WAIT || vblank) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Word for the upcoming state is registered on the transition edge
    case (state_d)
      ST_W_ATTR: begin
        writedata_d   = pack_word(desc_d.sub_comp, desc_d.child, WRITE_INFO, TYPE_ATTR,
                                  desc_d.pp_selc,
                                  attr_msg(desc_d.visible, desc_d.flip, desc_d.pattern));
        word_strobe_d = 1'b1;
      end
      ST_W_X: begin
        writedata_d   = pack_word(desc_d.sub_comp, desc_d.child, WRITE_INFO, TYPE_X,
                                  desc_d.pp_selc, coord_msg(desc_d.x));
        word_strobe_d = 1'b1;
      end
      ST_W_Y: begin
        writedata_d   = pack_word(desc_d.sub_comp, desc_d.child, WRITE_INFO, TYPE_Y,
                                  desc_d.pp_selc, coord_msg(desc_d.y));
        word_strobe_d = 1'b1;
      end
      ST_W_SHIFT: begin
        writedata_d   = pack_word(desc_d.sub_comp, desc_d.child, WRITE_INFO, TYPE_SHIFT,
                                  desc_d.pp_selc, coord_msg(desc_d.shift));
        word_strobe_d = 1'b1;
      end
      ST_FLUSH: begin
        writedata_d   = pack_word(SUB_W'(0), CHILD_W'(0), FLUSH_INFO, TYPE_NONE,
                                  ~front_buf_q, MSG_W'(0));
        word_strobe_d = 1'b1;
        front_buf_d   = ~front_buf_q;
      end
      default: ;
    endcase
  end

  assign idle_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      desc_q        <= '0;
      writedata_q   <= IDLE_WORD;
      word_strobe_q <= 1'b0;
      front_buf_q   <= 1'b0;
      idle_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      desc_q        <= desc_d;
      writedata_q   <= writedata_d;
      word_strobe_q <= word_strobe_d;
      front_buf_q   <= front_buf_d;
      idle_q        <= idle_d;
    end
  end

  assign writedata   = writedata_q;
  assign word_strobe = word_strobe_q;
  assign front_buf   = front_buf_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Scoreboard bench for sprite_cmd_encoder: drivers push expected words with their
// expected cycle, a negedge monitor pops and compares every emitted word.
module tb_sprite_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        spr_valid, spr_ready;
  logic [5:0]  spr_sub_comp;
  logic [4:0]  spr_child;
  logic        spr_visible, spr_flip;
  logic [4:0]  spr_pattern;
  logic [9:0]  spr_x, spr_y, spr_shift;
  logic        frame_valid, frame_ready, vblank;
  logic [31:0] writedata;
  logic        word_strobe, front_buf;

  sprite_cmd_encoder dut (
    .clk(clk), .reset(reset),
    .spr_valid(spr_valid), .spr_ready(spr_ready),
    .spr_sub_comp(spr_sub_comp), .spr_child(spr_child),
    .spr_visible(spr_visible), .spr_flip(spr_flip), .spr_pattern(spr_pattern),
    .spr_x(spr_x), .spr_y(spr_y), .spr_shift(spr_shift),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .vblank(vblank),
    .writedata(writedata), .word_strobe(word_strobe), .front_buf(front_buf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          cyc;
    bit          flush;
    bit          front_after;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   model_front = 1'b0;
  bit   mon_front = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference word built from the bus field layout with plain arithmetic
  function automatic logic [31:0] mk(input int sub, input int ch, input int info,
                                     input int typ, input int pp, input int msg);
    longint w;
    w = (longint'(sub) << 26) + (longint'(ch) << 21) + (longint'(info) << 17) +
        (longint'(typ) << 14) + (longint'(pp) << 13) + longint'(msg);
    return 32'(w);
  endfunction

  task automatic send_sprite(input int sub, input int ch, input int vis, input int fl,
                             input int pat, input int x, input int y, input int sh,
                             input bit hold, input bit use_lit, input logic [31:0] lit [4],
                             output int acc);
    int pp;
    exp_t e;
    spr_valid = 1'b1;
    spr_sub_comp = 6'(sub); spr_child = 5'(ch); spr_visible = 1'(vis); spr_flip = 1'(fl);
    spr_pattern = 5'(pat); spr_x = 10'(x); spr_y = 10'(y); spr_shift = 10'(sh);
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (spr_ready) begin acc = cyc + 1; break; end
      @(negedge clk);
    end
    chk("spr_accept_in_time", 32'(acc >= 0), 32'd1);
    if (acc < 0) begin spr_valid = 1'b0; return; end
    pp = model_front ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       e.word = mk(sub, ch, 1, 1, pp, vis * 4096 + fl * 2048 + pat);
        1:       e.word = mk(sub, ch, 1, 2, pp, x);
        2:       e.word = mk(sub, ch, 1, 3, pp, y);
        default: e.word = mk(sub, ch, 1, 4, pp, sh);
      endcase
      if (use_lit) e.word = lit[k];
      e.cyc = acc + k; e.flush = 1'b0; e.front_after = model_front;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) spr_valid = 1'b0;
  endtask

  task automatic send_frame(input int wait_cyc, input bit use_lit, input logic [31:0] lit,
                            output int acc);
    exp_t e;
    frame_valid = 1'b1;
    vblank = 1'b0;
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (frame_ready) begin acc = cyc + 1; break; end
      @(negedge clk);
    end
    chk("frame_accept_in_time", 32'(acc >= 0), 32'd1);
    if (acc < 0) begin frame_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int k = 0; k < wait_cyc; k++) @(negedge clk);
    vblank = 1'b1;
    e.word = use_lit ? lit : mk(0, 0, 15, 0, model_front ? 0 : 1, 0);
    e.cyc = cyc + 1; e.flush = 1'b1; e.front_after = !model_front;
    model_front = !model_front;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    vblank = 1'($urandom_range(0, 1));
  endtask

  // Monitor: every cycle out of reset either carries the next expected word or idles
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_front = 1'b0;
      end else begin
        if (word_strobe) begin
          if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'(word_strobe), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("word", writedata, e.word);
            chk("word_cycle", 32'(cyc), 32'(e.cyc));
            if (e.flush) mon_front = e.front_after;
          end
        end else begin
          chk("idle_word", writedata, 32'h0);
        end
        chk("front_buf", 32'(front_buf), 32'(mon_front));
      end
    end
  end

  initial begin
    logic [31:0] lit [4];
    logic [31:0] none [4];
    int a0, a1, a2, af;
    none = '{32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b0; spr_valid = 1'b0; frame_valid = 1'b0; vblank = 1'b0;
    spr_sub_comp = '0; spr_child = '0; spr_visible = 1'b0; spr_flip = 1'b0;
    spr_pattern = '0; spr_x = '0; spr_y = '0; spr_shift = '0;

    #1;
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_strobe", 32'(word_strobe), 32'd0);
    chk("rst_front_buf", 32'(front_buf), 32'd0);
    chk("rst_spr_ready", 32'(spr_ready), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    chk("spr_ready_after_reset", 32'(spr_ready), 32'd1);
    chk("writedata_after_reset", writedata, 32'h0);
    @(negedge clk);

    // Directed sprite with known encodings
    lit = '{32'h0C427001, 32'h0C42A064, 32'h0C42E0C8, 32'h0C432005};
    send_sprite(3, 2, 1, 0, 1, 100, 200, 5, 1'b0, 1'b1, lit, a0);
    repeat (6) @(negedge clk);

    // Flush after ten non-vblank cycles, then a sprite into the other buffer
    send_frame(10, 1'b1, 32'h001E2000, af);
    @(negedge clk);
    lit = '{mk(7, 1, 1, 1, 0, 4096 + 2048 + 31), mk(7, 1, 1, 2, 0, 1), mk(7, 1, 1, 3, 0, 2),
            mk(7, 1, 1, 4, 0, 3)};
    send_sprite(7, 1, 1, 1, 31, 1, 2, 3, 1'b0, 1'b1, lit, a0);
    repeat (5) @(negedge clk);

    // Simultaneous requests: sprite wins, frame waits for IDLE
    frame_valid = 1'b1;
    spr_valid = 1'b1;
    #1;
    chk("arb_frame_ready_low", 32'(frame_ready), 32'd0);
    chk("arb_spr_ready_high", 32'(spr_ready), 32'd1);
    send_sprite(9, 4, 0, 1, 6, 1023, 0, 512, 1'b0, 1'b0, none, a0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("arb_frame_ready_busy", 32'(frame_ready), 32'd0);
      @(negedge clk);
    end
    send_frame(0, 1'b0, 32'h0, af);
    chk("arb_frame_acc_gap", 32'(af - a0), 32'd5);
    repeat (3) @(negedge clk);

    // Back-to-back sprites with valid held high
    send_sprite(1, 1, 1, 0, 2, 10, 20, 30, 1'b1, 1'b0, none, a0);
    send_sprite(2, 3, 0, 0, 4, 40, 50, 60, 1'b1, 1'b0, none, a1);
    send_sprite(63, 31, 1, 1, 31, 70, 80, 90, 1'b0, 1'b0, none, a2);
    chk("b2b_gap_1", 32'(a1 - a0), 32'd5);
    chk("b2b_gap_2", 32'(a2 - a1), 32'd5);
    repeat (5) @(negedge clk);

    // Randomised mix of sprites, frames and idle gaps
    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        send_sprite(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    (r == 0), 1'b0, none, a0);
        if (r == 0) begin
          send_sprite(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), 1, 0,
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      1'b0, 1'b0, none, a1);
          chk("rand_b2b_gap", 32'(a1 - a0), 32'd5);
        end
      end else if (r < 8) begin
        send_frame(int'($urandom_range(0, 5)), 1'b0, 32'h0, af);
      end else begin
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);

    // Make the front buffer 1, then reset in the middle of a sprite (during W_Y)
    if (!model_front) send_frame(0, 1'b0, 32'h0, af);
    repeat (2) @(negedge clk);
    chk("pre_reset_front_buf", 32'(front_buf), 32'd1);
    send_sprite(5, 5, 1, 1, 5, 5, 5, 5, 1'b0, 1'b0, none, a0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_writedata", writedata, 32'h0);
    chk("async_rst_strobe", 32'(word_strobe), 32'd0);
    chk("async_rst_front_buf", 32'(front_buf), 32'd0);
    sb.delete();
    model_front = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    chk("spr_ready_after_mid_reset", 32'(spr_ready), 32'd1);
    repeat (6) @(negedge clk);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
